// File: rtl/fir_stream_ctrl.sv
// Streaming sequencer for an enable-equipped FIR core: input/output FIFOs, frame flush/drain
// and result tagging, with the core stalled whenever the output side cannot take a result.
`timescale 1ns/1ps
module fir_stream_ctrl #(
  parameter int          DW         = 16,
  parameter int          IN_DEPTH   = 8,
  parameter int          OUT_DEPTH  = 8,
  parameter int          TAPS       = 3,
  parameter int          FIR_LAT    = 1,
  parameter logic [15:0] FRAMES_RST = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_last,
  output logic signed [DW-1:0] fir_x,
  output logic                 fir_en,
  input  logic signed [DW-1:0] fir_y,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic [15:0]          frames_done
);

  // state | meaning
  // IDLE  | no frame in progress, waiting for buffered input
  // FLUSH | TAPS-1 zero steps clear the delay line
  // RUN   | one buffered sample issued per enabled step
  // DRAIN | FIR_LAT zero steps push the last result out
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int            IAW      = $clog2(IN_DEPTH);
  localparam int            OAW      = $clog2(OUT_DEPTH);
  localparam int            CW       = 8;
  localparam logic [CW-1:0] FLUSH_LD = CW'(TAPS - 2);
  localparam logic [CW-1:0] DRAIN_LD = CW'(FIR_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IAW:0]  IN_ONE   = (IAW+1)'(1);
  localparam logic [OAW:0]  OUT_ONE  = (OAW+1)'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   frames_q, frames_d;

  logic [DW:0]  in_mem_q [IN_DEPTH];
  logic [IAW:0] in_wr_q, in_rd_q;
  logic         in_empty, in_full, in_push, in_pop;
  logic [DW:0]  in_head;

  logic [DW:0]  out_mem_q [OUT_DEPTH];
  logic [OAW:0] out_wr_q, out_rd_q;
  logic         out_empty, out_full, out_push, out_pop;
  logic [DW:0]  out_head;

  logic [FIR_LAT-1:0] tag_v_q, tag_last_q;
  logic               tail_v, tail_last, tag_v_in, tag_last_in;
  logic               want, adv, run_issue;

  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) && (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign in_head   = in_mem_q[in_rd_q[IAW-1:0]];
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) && (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
  assign out_head  = out_mem_q[out_rd_q[OAW-1:0]];

  assign tail_v    = tag_v_q[FIR_LAT-1];
  assign tail_last = tag_last_q[FIR_LAT-1];

  always_comb begin
    want = 1'b0;
    case (state_q)
      ST_FLUSH: want = 1'b1;
      ST_RUN:   want = !in_empty;
      ST_DRAIN: want = 1'b1;
      default:  want = 1'b0;
    endcase
  end

  // A valid result at the tail needs a free output slot before the core may step.
  assign adv         = want && !(tail_v && out_full) && !rst;
  assign run_issue   = adv && (state_q == ST_RUN);
  assign in_push     = s_valid && s_ready;
  assign in_pop      = run_issue;
  assign out_push    = adv && tail_v;
  assign out_pop     = m_valid && m_ready;
  assign tag_v_in    = run_issue;
  assign tag_last_in = run_issue && in_head[DW];

  assign s_ready     = !in_full && !rst;
  assign m_valid     = !out_empty && !rst;
  assign m_data      = m_valid ? out_head[DW-1:0] : '0;
  assign m_last      = m_valid && out_head[DW];
  assign fir_en      = adv;
  assign fir_x       = run_issue ? in_head[DW-1:0] : '0;
  assign busy        = (state_q != ST_IDLE) && !rst;
  assign frames_done = frames_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (!in_empty) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LD;
        end
      end
      ST_FLUSH: begin
        if (adv) begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (adv && in_head[DW]) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      ST_DRAIN: begin
        if (adv) begin
          if (cnt_q == '0) begin
            state_d  = ST_IDLE;
            frames_d = frames_q + 16'd1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      frames_q   <= FRAMES_RST;
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      tag_v_q    <= '0;
      tag_last_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      if (in_push)  in_wr_q  <= in_wr_q + IN_ONE;
      if (in_pop)   in_rd_q  <= in_rd_q + IN_ONE;
      if (out_push) out_wr_q <= out_wr_q + OUT_ONE;
      if (out_pop)  out_rd_q <= out_rd_q + OUT_ONE;
      if (adv) begin
        for (int i = FIR_LAT - 1; i > 0; i--) begin
          tag_v_q[i]    <= tag_v_q[i-1];
          tag_last_q[i] <= tag_last_q[i-1];
        end
        tag_v_q[0]    <= tag_v_in;
        tag_last_q[0] <= tag_last_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q[IAW-1:0]]   <= {s_last, s_data};
    if (out_push) out_mem_q[out_wr_q[OAW-1:0]] <= {tail_last, fir_y};
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a behavioural 3-tap FIR core (latency 1) in the loop.
`timescale 1ns/1ps
module tb_fir_stream_ctrl;
  localparam int DW = 16;
  localparam int H0 = 3;
  localparam int H1 = -2;
  localparam int H2 = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] fir_x, fir_y, m_data;
  logic          s_ready, fir_en, m_valid, m_last, busy;
  logic [15:0]   frames_done;

  logic [DW-1:0] w_fir_x, w_m_data;
  logic          w_s_ready, w_fir_en, w_m_valid, w_m_last, w_busy;
  logic [15:0]   w_frames;

  int n_chk = 0, n_fail = 0;
  int en_cnt = 0, zero_en_cnt = 0;
  int fexp = 0, fexp2 = 'hFFF0;
  logic [DW:0] got_q[$], exp_q[$];

  typedef struct {int din; logic lin; int dexp; logic lexp;} vec_t;
  vec_t tv[4];

  always #5 clk = ~clk;

  fir_stream_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .fir_x(fir_x), .fir_en(fir_en), .fir_y(fir_y), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .frames_done(frames_done));

  // Same stimulus, counter starting near its wrap point.
  fir_stream_ctrl #(.FRAMES_RST(16'hFFF0)) dut_w (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(w_s_ready), .s_data(s_data), .s_last(s_last),
    .fir_x(w_fir_x), .fir_en(w_fir_en), .fir_y(fir_y), .m_valid(w_m_valid), .m_ready(m_ready),
    .m_data(w_m_data), .m_last(w_m_last), .busy(w_busy), .frames_done(w_frames));

  logic signed [DW-1:0] fd1 = '0, fd2 = '0, fy = '0;
  assign fir_y = fy;
  always @(posedge clk) begin
    if (fir_en) begin
      fy  <= DW'(H0 * $signed(fir_x) + H1 * fd1 + H2 * fd2);
      fd1 <= fir_x;
      fd2 <= fd1;
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_data});
    if (fir_en) begin
      en_cnt++;
      if (fir_x == '0) zero_en_cnt++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] gold(input int xs[$], input int k);
    int acc;
    acc = H0 * xs[k];
    if (k >= 1) acc += H1 * xs[k-1];
    if (k >= 2) acc += H2 * xs[k-2];
    return DW'(acc);
  endfunction

  task automatic add_exp(input int xs[$]);
    for (int k = 0; k < xs.size(); k++) exp_q.push_back({(k == xs.size() - 1), gold(xs, k)});
  endtask

  task automatic push(input int d, input logic l);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = DW'(d);
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 2000) begin
        check("push_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send(input int xs[$]);
    for (int k = 0; k < xs.size(); k++) push(xs[k], k == xs.size() - 1);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while ((got_q.size() < n || busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("out_count", got_q.size(), n);
  endtask

  task automatic compare_q(input string nm);
    logic [DW:0] g, e;
    check({nm, "_len"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({nm, "_data"}, int'(g[DW-1:0]), int'(e[DW-1:0]));
      check({nm, "_last"}, int'(g[DW]), int'(e[DW]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_frames(input string nm);
    check({nm, "_frames"}, int'(frames_done), fexp & 'hFFFF);
    check({nm, "_frames_w"}, int'(w_frames), fexp2 & 'hFFFF);
  endtask

  task automatic check_in_reset(input string nm);
    check({nm, "_s_ready"}, int'(s_ready), 0);
    check({nm, "_m_valid"}, int'(m_valid), 0);
    check({nm, "_fir_en"}, int'(fir_en), 0);
    check({nm, "_fir_x"}, int'(fir_x), 0);
    check({nm, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa[$], fb[$], fc[$], gaps[$];
    logic [DW:0] g;

    tv[0] = '{100, 1'b0,  300, 1'b0};
    tv[1] = '{200, 1'b0,  400, 1'b0};
    tv[2] = '{300, 1'b0, 1000, 1'b0};
    tv[3] = '{400, 1'b1, 1600, 1'b1};

    // reset
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b1;
    @(negedge clk);
    check_in_reset("rst");
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_frames("rst");
    check("rst_rel_s_ready", int'(s_ready), 1);
    check("rst_rel_m_valid", int'(m_valid), 0);
    check("rst_rel_busy", int'(busy), 0);
    @(posedge clk); #1;

    // single frame from the vector table
    m_ready = 1'b1;
    en_cnt = 0;
    zero_en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({tv[i].lexp, DW'(tv[i].dexp)});
      push(tv[i].din, tv[i].lin);
    end
    wait_done(4);
    compare_q("single");
    check("single_en_cnt", en_cnt, 7);
    check("single_zero_steps", zero_en_cnt, 3);
    fexp++; fexp2++;
    check_frames("single");

    // output backpressure, then input FIFO fill
    m_ready = 1'b0;
    en_cnt = 0;
    fa.delete();
    for (int k = 0; k < 12; k++) fa.push_back(k * 100 - 550);
    fb = '{9, -9, 18, -18, 27, -27};
    add_exp(fa);
    add_exp(fb);
    send(fa);
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_en_cnt", en_cnt, 11);
    check("bp_m_valid", int'(m_valid), 1);
    check("bp_fir_en", int'(fir_en), 0);
    check("bp_busy", int'(busy), 1);
    check("bp_s_ready", int'(s_ready), 1);
    check("bp_no_out", got_q.size(), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) push(fb[k], 1'b0);
    @(negedge clk);
    check("bp_in_full", int'(s_ready), 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    push(fb[5], 1'b1);
    wait_done(18);
    compare_q("bp");
    check("bp_en_total", en_cnt, 24);
    fexp += 2; fexp2 += 2;
    check_frames("bp");

    // input bubbles
    en_cnt = 0;
    fc   = '{40, -25, 13, 70, -60, 5};
    gaps = '{3, 1, 3, 2, 2, 0};
    add_exp(fc);
    for (int k = 0; k < 6; k++) begin
      push(fc[k], k == 5);
      for (int j = 0; j < gaps[k]; j++) begin
        @(negedge clk);
        if (k >= 2 && j >= 1) check("gap_fir_en", int'(fir_en), 0);
        @(posedge clk); #1;
      end
    end
    wait_done(6);
    compare_q("bubble");
    check("bubble_en_cnt", en_cnt, 9);
    fexp++; fexp2++;
    check_frames("bubble");

    // back-to-back frames
    en_cnt = 0;
    fa = '{1000, -1000, 500};
    fb = '{7, 7, 7};
    add_exp(fa);
    add_exp(fb);
    send(fa);
    send(fb);
    wait_done(6);
    if (got_q.size() > 3) begin
      g = got_q[3];
      check("b2b_first_b", int'(g[DW-1:0]), 21);
    end
    compare_q("b2b");
    check("b2b_en_cnt", en_cnt, 12);
    fexp += 2; fexp2 += 2;
    check_frames("b2b");

    // reset mid-frame
    push(11, 1'b0);
    push(22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_in_reset("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    fexp = 0; fexp2 = 'hFFF0;
    @(negedge clk);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_fir_en", int'(fir_en), 0);
    check("midrst_s_ready", int'(s_ready), 1);
    check_frames("midrst");
    repeat (4) @(negedge clk);
    check("midrst_busy_later", int'(busy), 0);
    check("midrst_no_out", got_q.size(), 0);
    @(posedge clk); #1;
    fa = '{10, 20};
    check("post_rst_gold0", int'(gold(fa, 0)), 30);
    check("post_rst_gold1", int'(gold(fa, 1)), 40);
    add_exp(fa);
    send(fa);
    wait_done(2);
    compare_q("post_rst");
    fexp++; fexp2++;
    check_frames("post_rst");

    // single-sample frames across the counter wrap
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fexp = 0; fexp2 = 'hFFF0;
    for (int f = 0; f < 16; f++) begin
      exp_q.push_back({1'b1, DW'(15)});
      send('{5});
      wait_done(1);
      compare_q("wrap");
      fexp++; fexp2++;
      check_frames("wrap");
    end
    check("wrap_zero", int'(w_frames), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
- Streaming sequencer for the 3-tap FIR core (enable-equipped variant); owns all FIR stepping.
- Buffers incoming samples with a valid/ready input and drives the core's x input and clock enable.
- Clears the delay line with zero samples at each frame start, and drains the pipeline at frame end.
- Tags results and delivers them through a valid/ready output FIFO; stalls the core under backpressure so no sample is lost.

Parameters:
- DW, 16, sample width, signed, both x and y.
- IN_DEPTH, 8, input FIFO depth, power of 2.
- OUT_DEPTH, 8, output FIFO depth, power of 2.
- TAPS, 3, FIR taps; the flush length is TAPS-1.
- FIR_LAT, 1, number of enabled cycles from x to the matching y, ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input FIFO not full.
- s_data  in  DW  input sample, signed.
- s_last  in  1  last sample of the frame.
- fir_x  out  DW  FIR input; combinational, zero unless a sample is being issued.
- fir_en  out  1  FIR advance enable; combinational.
- fir_y  in  DW  FIR output.
- m_valid  out  1  output FIFO not empty.
- m_ready  in  1  downstream accepts.
- m_data  out  DW  filtered sample.
- m_last  out  1  marks the result of the s_last sample.
- busy  out  1  state is not IDLE.
- frames_done  out  16  count of completed frames; wraps at 0xFFFF → 0.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE. Both FIFOs and the tag pipe are cleared. frames_done=0.
  - While rst=1: s_ready=0, m_valid=0, fir_en=0, fir_x=0, busy=0.
  - A reset mid-frame discards all in-flight data. The next frame starts with a full flush.
- Input FIFO: a push happens when s_valid&&s_ready; each entry is {data,last}. There is no bypass; s_ready=!in_full.
- Output FIFO: a pop happens when m_valid&&m_ready; m_data/m_last come from the head entry. m_valid=!out_empty.
- Tag pipe: FIR_LAT stages of {v,last}.
  - It shifts only when fir_en=1.
  - The tail stage corresponds to the current fir_y.
- Advance condition: adv = want && !(tail.v && out_full).
  - On an adv cycle with tail.v=1, {fir_y, tail.last} is pushed to the output FIFO before the shift.
  - A pop and a push in the same cycle are legal; "full" is evaluated before the pop, which is conservative.
- States:
  - IDLE: want=0.
    - When the input FIFO is non-empty, go to FLUSH with fcnt=0.
  - FLUSH: want=1, fir_x=0, an untagged entry enters the pipe.
    - fcnt counts adv cycles. After TAPS-1 adv cycles, go to RUN.
  - RUN: want=!in_empty.
    - On adv: pop the input FIFO, fir_x=head.data, and enter tag {1, head.last}.
    - If head.last, go to DRAIN with dcnt=0.
    - An empty input FIFO mid-frame means fir_en=0, so the FIR holds (bubble-free filtering).
  - DRAIN: want=1, fir_x=0, untagged entries.
    - After FIR_LAT adv cycles, frames_done++ and go to IDLE.
- When the input FIFO is empty and state is not RUN, fir_x is held at 0.
- Stall: while adv=0, fir_en=0 and no FIFO, pipe or counter changes, apart from external push/pop.
- Back-to-back frames: IDLE lasts exactly one cycle if data is pending, so every frame is preceded by exactly TAPS-1 zero flush steps.
- Outputs per frame equal inputs per frame, in order. m_last is asserted exactly once per frame.
- A frame of length 1 (s_last on the first sample) is legal.

Test Plan:
- Single frame: defaults, m_ready=1, frame 100,200,300,400 with last on 400.
  - 2 zero flush steps occur, then 4 outputs matching the golden 3-tap model with zero history, then 1 drain step.
  - m_last only on the 4th output.
  - fir_en high for 7 cycles total; frames_done=1.
- Output backpressure: m_ready=0, 12-sample frame.
  - Exactly 8 outputs are queued and fir_en drops with tail.v=1.
  - s_ready drops once 8 samples are buffered.
  - After m_ready=1, all 12 outputs arrive in order and none are lost or duplicated.
- Input bubbles: 6-sample frame with s_valid gaps of 1–3 cycles.
  - fir_en=0 during every gap.
  - The output sequence is bit-identical to the gapless run.
- Back-to-back frames: A=[1000,-1000,500] then B=[7,7,7] with no idle gap.
  - The first B output equals h0·7 only, showing the flush erased A's history.
  - frames_done=2.
- Reset mid-frame: rst for 1 cycle after 2 of 5 samples.
  - All outputs are low next cycle, both FIFOs are empty, and no partial output appears.
  - A new frame 10,20 then yields its golden outputs.
- Wrap and single-sample: preload frames_done=0xFFFF via 65535 single-sample frames (value 5).
  - Each frame yields one output h0·5 with m_last=1.
  - One more frame wraps frames_done to 0x0000.
